// File: rtl/cpu_pkg.sv
// Shared definitions for the result byte transmitter: FSM states,
// byte width, and helpers for the derived word geometry.
package cpu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Number of bytes in a word of the given width.
    function automatic int nbytes_of(input int datawidth);
        return datawidth / BYTE_W;
    endfunction

    // Byte index width; a one-byte word still keeps a 1-bit index.
    function automatic int idxw_of(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/result_byte_shifter.sv
// Word shift register that presents one byte at a time, LSB first, and
// tracks which byte of the word is currently on the output.
module result_byte_shifter
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 clear,
    input  logic [DATAWIDTH-1:0] load_data,
    output logic [BYTE_W-1:0]    byte_out,
    output logic                 first_flag,
    output logic                 last_flag
);

    localparam int NBYTES = nbytes_of(DATAWIDTH);
    localparam int IDXW   = idxw_of(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    logic [DATAWIDTH-1:0] shift_q, shift_d;
    logic [IDXW-1:0]      idx_q, idx_d;

    // Next shifter contents: clear wins, then a fresh load, then a byte step.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (load) begin
            shift_d = load_data;
            idx_d   = '0;
        end else if (advance) begin
            shift_d = shift_q >> BYTE_W;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
        end
    end

    // Shifter and byte index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_out   = shift_q[BYTE_W-1:0];
    assign first_flag = (idx_q == '0);
    assign last_flag  = (idx_q == LAST_IDX);

endmodule

// File: rtl/result_byte_tx.sv
// Serialises result words onto a byte bus, LSB first, with frame markers.
// One word drains from the shifter while a second can wait in the pending
// slot, so a new word hands over on the cycle after the last byte.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing in the shifter, byteValid low
//   SEND  | shifter holds a word, byteValid high until its last byte
module result_byte_tx
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] wordIn,
    input  logic                 wordValid,
    output logic                 wordReady,
    output logic [BYTE_W-1:0]    byteOut,
    output logic                 byteValid,
    input  logic                 byteReady,
    output logic                 firstByte,
    output logic                 lastByte,
    output logic                 busy
);

    tx_state_e            state_q, state_d;
    logic [DATAWIDTH-1:0] pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;

    logic                 sh_load, sh_advance, sh_clear;
    logic [DATAWIDTH-1:0] sh_data;
    logic [BYTE_W-1:0]    sh_byte;
    logic                 sh_first, sh_last;

    logic accept, xfer, end_of_word;

    assign accept      = wordValid && wordReady;
    assign xfer        = (state_q == SEND) && byteReady;
    assign end_of_word = xfer && sh_last;

    // Next-state, pending-slot and shifter control decisions.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        sh_load     = 1'b0;
        sh_advance  = 1'b0;
        sh_clear    = 1'b0;
        sh_data     = wordIn;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (end_of_word) begin
                    // A pending word always has priority; wordReady is low
                    // while it is held, so no new accept can collide here.
                    if (pend_full_q) begin
                        sh_load     = 1'b1;
                        sh_data     = pend_q;
                        pend_full_d = 1'b0;
                    end else if (accept) begin
                        sh_load = 1'b1;
                    end else begin
                        sh_clear = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    sh_advance = xfer;
                    if (accept) begin
                        pend_d      = wordIn;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and pending slot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    result_byte_shifter #(
        .DATAWIDTH(DATAWIDTH)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .advance   (sh_advance),
        .clear     (sh_clear),
        .load_data (sh_data),
        .byte_out  (sh_byte),
        .first_flag(sh_first),
        .last_flag (sh_last)
    );

    // Outputs depend on registered state only; flags are masked in IDLE.
    assign wordReady = !pend_full_q;
    assign byteValid = (state_q == SEND);
    assign byteOut   = byteValid ? sh_byte : '0;
    assign firstByte = byteValid && sh_first;
    assign lastByte  = byteValid && sh_last;
    assign busy      = byteValid || pend_full_q;

endmodule

// File: doc/result_byte_tx.md
Name: result_byte_tx

Overview:
Serialises full-width CPU results (e.g. the registered ALU result) onto an 8-bit output bus with a valid/ready handshake. It is the outbound counterpart of the byte-wide program-load path: bytes leave least-significant first and carry frame markers. One word is in flight plus one pending word, so a new result can be accepted while the current one is still draining.

Parameters:
DATAWIDTH, 32, width of an input word; must be a multiple of 8 and at least 8
NBYTES, DATAWIDTH/8, bytes per word (derived localparam, not overridable)
IDXW, clog2(NBYTES) with a minimum of 1, width of the byte index (derived localparam)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
wordIn  input  DATAWIDTH  result word to transmit
wordValid  input  1  wordIn is valid this cycle
wordReady  output  1  block can accept a word; equals !pendFull (registered state only, no combinational path from byteReady)
byteOut  output  8  current byte, LSB-first
byteValid  output  1  byteOut valid
byteReady  input  1  downstream accepts byteOut at this rising edge
firstByte  output  1  byteOut is byte 0 of a word
lastByte  output  1  byteOut is byte NBYTES-1 of a word
busy  output  1  shifter or pending slot occupied

Behaviour:
- Reset (rst low, asynchronous): state IDLE, byteIdx=0, shifter=0, pend=0, pendFull=0. Outputs after reset: byteValid=0, byteOut=0, firstByte=0, lastByte=0, busy=0, wordReady=1.
- Word accept: a word is taken when wordValid && wordReady at a rising edge.
- Byte transfer: a byte completes when byteValid && byteReady at a rising edge.
- States: IDLE, SEND.
- IDLE:
  - On accept: load shifter=wordIn, byteIdx=0, go to SEND.
  - byteValid rises the next cycle (latency 1).
- SEND:
  - byteValid=1; byteOut=shifter[7:0].
  - firstByte = (byteIdx==0); lastByte = (byteIdx==NBYTES-1).
  - byteOut and the flags stay stable while byteReady=0 (no drop, no change).
- Byte completes with byteIdx<NBYTES-1: shifter shifts right by 8 (zero fill), byteIdx+1.
- Byte completes with byteIdx==NBYTES-1 (end of word):
  - If pendFull: shifter=pend, pendFull=0, byteIdx=0, stay in SEND. No bubble cycle.
  - Else, if an accept occurs in the same cycle: shifter=wordIn, byteIdx=0, stay in SEND. No bubble cycle.
  - Else: go to IDLE, byteIdx=0.
- Accept while in SEND and not completing the last byte: pend=wordIn, pendFull=1.
- When pendFull=1, wordReady=0. It returns to 1 the cycle after pend moves into the shifter.
- byteIdx wraps only through the end-of-word path. It never exceeds NBYTES-1.
- NBYTES==1: firstByte and lastByte are both 1 on every byte.
- busy = (state==SEND) || pendFull.
- Reset asserted mid-word: the partial word and the pending word are discarded. Transmission never resumes.
- wordValid while wordReady=0: ignored. The upstream must hold the word; this block never overwrites pend.

Decomposition:
- Shared package (cpu_pkg): the state enum {IDLE, SEND}, BYTE_W=8, and a helper function for NBYTES/IDXW.
- One natural sub-module: result_byte_shifter (shift register + byteIdx + first/last flags), with load, advance and clear controls.
- The FSM and the pending slot stay in result_byte_tx.

Test Plan:
1. Reset, then wordIn=32'hDEADBEEF for one valid cycle with byteReady held 1 -> byteOut = EF, BE, AD, DE on 4 consecutive cycles starting 1 cycle after accept; firstByte on EF, lastByte on DE; then IDLE with byteValid=0 and busy=0.
2. Back-to-back: 32'h03020100 accepted, then 32'h07060504 offered next cycle -> second word goes to pend, wordReady=0 until handoff; 8 contiguous bytes 00..07 with no bubble between 03 and 04.
3. Backpressure: byteReady=0 for 5 cycles mid-word, with byteIdx=2 on 32'h11223344 -> byteOut holds 22 with byteValid=1 for all 5 cycles; then 11 with lastByte=1.
4. Simultaneous end-of-word and accept, pend empty: 32'hAABBCCDD offered in the same cycle that the last byte of the previous word completes -> DD appears the next cycle with firstByte=1.
5. Async reset: rst pulled low mid-cycle while sending byte 1 of 32'hCAFEF00D with a word pending -> outputs clear immediately without a clock edge; after release, no residual bytes; wordReady=1.
6. Parameter DATAWIDTH=8: words 8'h5A and 8'hA5 -> one byte each, with firstByte=lastByte=1 on every byte.
